// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle controller (states, opcodes, mux selects, ALU codes)
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_RDATA     = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format follows the opcode alone, independent of state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] r_imm;
        case (op)
            OP_SW:   r_imm = IMM_S;
            OP_BEQ:  r_imm = IMM_B;
            OP_JAL:  r_imm = IMM_J;
            default: r_imm = IMM_I;
        endcase
        return r_imm;
    endfunction

endpackage

// File: rtl/mc_alu_op_decoder.sv
// rtl/mc_alu_op_decoder.sv - maps the FSM's ALU operation class plus funct fields to ALUControl
module mc_alu_op_decoder
    import mc_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    input  logic [6:0] i_op,
    output logic [2:0] o_alu_control
);

    logic [2:0] w_alu_control;
    logic       w_is_sub;
    logic       w_unused_bits;

    // Only R-type (Op[5]=1) with funct7[5] selects sub; addi never subtracts.
    assign w_is_sub      = i_op[5] & i_funct7[5];
    assign w_unused_bits = ^{i_funct7[6], i_funct7[4:0], i_op[6], i_op[4:0]};

    always_comb begin
        w_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: w_alu_control = ALU_ADD;
            ALUOP_SUB: w_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  w_alu_control = w_is_sub ? ALU_SUB : ALU_ADD;
                    3'b010:  w_alu_control = ALU_SLT;
                    3'b110:  w_alu_control = ALU_OR;
                    3'b111:  w_alu_control = ALU_AND;
                    default: w_alu_control = ALU_ADD;
                endcase
            end
            default: w_alu_control = ALU_ADD;
        endcase
    end

    assign o_alu_control = w_alu_control;

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V sequencing FSM; MC_ILLEGAL_TRAP_EN adds TRAP state and illegal_op
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int         STATE_W     = 4,
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         Op,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic               instr_done,
    output logic [STATE_W-1:0] state_o
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    output logic               illegal_op
`endif
);

    state_t     r_state;
    state_t     w_next_state;
    alu_op_t    w_alu_op;
    logic       w_pc_write;
    logic       w_adr_src;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_instr_done;
    logic [1:0] w_result_src;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= state_t'(RESET_STATE);
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        w_alu_op     = ALUOP_ADD;
        w_pc_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_instr_done = 1'b0;
        w_result_src = RES_ALUOUT;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_RS2;

        case (r_state)
            S_FETCH: begin
                w_adr_src    = 1'b0;
                w_src_a      = SRCA_PC;
                w_src_b      = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_ir_write   = mem_ready;
                w_pc_write   = mem_ready;
                w_next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is computed here so BEQ only needs the compare.
                w_src_a = SRCA_OLDPC;
                w_src_b = SRCB_IMM;
                case (Op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTER;
                    OP_ITYPE:     w_next_state = S_EXECUTEI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JAL;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        w_next_state = S_TRAP;
`else
                        w_next_state = S_FETCH;
                        w_instr_done = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                w_src_a      = SRCA_RS1;
                w_src_b      = SRCB_IMM;
                w_next_state = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_result_src = RES_ALUOUT;
                w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_result_src = RES_RDATA;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe stays high for the whole wait so slow memories see a stable write.
                w_adr_src    = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = mem_ready;
                w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                w_src_a      = SRCA_RS1;
                w_src_b      = SRCB_RS2;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_src_a      = SRCA_RS1;
                w_src_b      = SRCB_IMM;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_result_src = RES_ALUOUT;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                w_src_a      = SRCA_RS1;
                w_src_b      = SRCB_RS2;
                w_alu_op     = ALUOP_SUB;
                w_result_src = RES_ALUOUT;
                w_pc_write   = Zero;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                // PC takes the jump target from ALUOut while PC+4 is formed for rd in ALUWB.
                w_src_a      = SRCA_OLDPC;
                w_src_b      = SRCB_FOUR;
                w_result_src = RES_ALUOUT;
                w_pc_write   = 1'b1;
                w_next_state = S_ALUWB;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_next_state = S_TRAP;
            end
`endif
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    mc_alu_op_decoder u_alu_op_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7      (funct7),
        .i_op          (Op),
        .o_alu_control (ALUControl)
    );

    assign PCWrite    = w_pc_write   & ~rst;
    assign IRWrite    = w_ir_write   & ~rst;
    assign MemWrite   = w_mem_write  & ~rst;
    assign RegWrite   = w_reg_write  & ~rst;
    assign instr_done = w_instr_done & ~rst;
    assign AdrSrc     = w_adr_src;
    assign ResultSrc  = w_result_src;
    assign ALUSrcA    = w_src_a;
    assign ALUSrcB    = w_src_b;
    assign ImmSrc     = imm_src_of(Op);
    assign state_o    = STATE_W'(r_state);

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_op = (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed and random instruction walks checked against a per-cycle expectation model
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, instr_done;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal_op;
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .instr_done (instr_done),
        .state_o    (state_o)
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // One expected cycle; -1 in a field means the value is unconstrained in that state.
    typedef struct {
        int st, pcw, adr, irw, mw, rw, rs, sa, sb, ac, done;
        bit mr, z;
    } cyc_t;
    cyc_t q[$];

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_NOP = 6;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push(int st, int pcw, int adr, int irw, int mw, int rw, int rs,
                                 int sa, int sb, int ac, int done, bit mr, bit z);
        cyc_t c;
        c.st = st; c.pcw = pcw; c.adr = adr; c.irw = irw; c.mw = mw; c.rw = rw;
        c.rs = rs; c.sa = sa; c.sb = sb; c.ac = ac; c.done = done; c.mr = mr; c.z = z;
        q.push_back(c);
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int funct_ctl(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
        case (f3)
            3'd0:    return (op[5] && f7[5]) ? 1 : 0;
            3'd2:    return 5;
            3'd6:    return 3;
            3'd7:    return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] op);
        case (op)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic bit supported(logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    endfunction

    function automatic logic [20:0] f_val(cyc_t c, logic [1:0] imm);
        logic [3:0] st;
        st = 4'(c.st);
        return {st, c.pcw[0], c.adr[0], c.irw[0], c.mw[0], c.rw[0], c.rs[1:0],
                c.sa[1:0], c.sb[1:0], c.ac[2:0], c.done[0], imm};
    endfunction

    function automatic logic [20:0] f_mask(cyc_t c);
        logic [20:0] m;
        m = '1;
        if (c.adr < 0) m[15]    = 1'b0;
        if (c.rs < 0)  m[11:10] = 2'b00;
        if (c.sa < 0)  m[9:8]   = 2'b00;
        if (c.sb < 0)  m[7:6]   = 2'b00;
        if (c.ac < 0)  m[5:3]   = 3'b000;
        return m;
    endfunction

    // Expected cycle list for one instruction, built from the per-state rules.
    function automatic int build(int kind, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                 int sf, int sm, bit z);
        int fc;
        int lat;
        fc = funct_ctl(op, f3, f7);
        for (int i = 0; i < sf; i++) push(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 1'b0, rb());
        push(0, 1, 0, 1, 0, 0, 2, 0, 2, 0, 0, 1'b1, rb());
        push(1, 0, -1, 0, 0, 0, -1, 1, 1, 0, (kind == K_NOP && !TRAP_EN) ? 1 : 0, rb(), rb());
        case (kind)
            K_LW: begin
                push(2, 0, -1, 0, 0, 0, -1, 2, 1, 0, 0, rb(), rb());
                for (int i = 0; i < sm; i++) push(3, 0, 1, 0, 0, 0, 0, -1, -1, -1, 0, 1'b0, rb());
                push(3, 0, 1, 0, 0, 0, 0, -1, -1, -1, 0, 1'b1, rb());
                push(4, 0, -1, 0, 0, 1, 1, -1, -1, -1, 1, rb(), rb());
                lat = 5 + sf + sm;
            end
            K_SW: begin
                push(2, 0, -1, 0, 0, 0, -1, 2, 1, 0, 0, rb(), rb());
                for (int i = 0; i < sm; i++) push(5, 0, 1, 0, 1, 0, -1, -1, -1, -1, 0, 1'b0, rb());
                push(5, 0, 1, 0, 1, 0, -1, -1, -1, -1, 1, 1'b1, rb());
                lat = 4 + sf + sm;
            end
            K_R, K_I: begin
                push(kind == K_R ? 6 : 7, 0, -1, 0, 0, 0, -1, 2, kind == K_R ? 0 : 1, fc, 0, rb(), rb());
                push(8, 0, -1, 0, 0, 1, 0, -1, -1, -1, 1, rb(), rb());
                lat = 4 + sf;
            end
            K_BEQ: begin
                push(9, z ? 1 : 0, -1, 0, 0, 0, 0, 2, 0, 1, 1, rb(), z);
                lat = 3 + sf;
            end
            K_JAL: begin
                push(10, 1, -1, 0, 0, 0, 0, 1, 2, 0, 0, rb(), rb());
                push(8, 0, -1, 0, 0, 1, 0, -1, -1, -1, 1, rb(), rb());
                lat = 4 + sf;
            end
            default: begin
                if (TRAP_EN) begin
                    for (int i = 0; i < 4; i++) push(11, 0, -1, 0, 0, 0, -1, -1, -1, -1, 0, rb(), rb());
                    lat = -1;
                end else begin
                    lat = 2 + sf;
                end
            end
        endcase
        return lat;
    endfunction

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b1; Zero = 1'b1;
        #1;
        chk("reset1/enables", {PCWrite, IRWrite, MemWrite, RegWrite, instr_done}, 0);
        @(negedge clk);
        #1;
        chk("reset2/enables", {PCWrite, IRWrite, MemWrite, RegWrite, instr_done}, 0);
        chk("reset2/state", state_o, 0);
`ifdef MC_ILLEGAL_TRAP_EN
        chk("reset2/illegal_op", illegal_op, 0);
`endif
        @(negedge clk);
    endtask

    task automatic run_instr(input string name, input int kind, input logic [6:0] op,
                             input logic [2:0] f3, input logic [6:0] f7,
                             input int sf, input int sm, input bit z, input int abort_at);
        int exp_lat;
        int done_at;
        logic [20:0] obs, m;
        done_at = -1;
        Op = op; funct3 = f3; funct7 = f7;
        exp_lat = build(kind, op, f3, f7, sf, sm, z);
        for (int i = 0; i < q.size(); i++) begin
            if (i == abort_at) begin
                rst = 1'b1; mem_ready = 1'b1; Zero = 1'b1;
                #1;
                chk({name, "/abort_enables"}, {PCWrite, IRWrite, MemWrite, RegWrite, instr_done}, 0);
                @(negedge clk);
                #1;
                chk({name, "/abort_state"}, state_o, 0);
                chk({name, "/abort_enables2"}, {PCWrite, IRWrite, MemWrite, RegWrite, instr_done}, 0);
                @(negedge clk);
                q.delete();
                return;
            end
            rst = 1'b0; mem_ready = q[i].mr; Zero = q[i].z;
            #1;
            obs = {state_o, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ALUControl, instr_done, ImmSrc};
            m = f_mask(q[i]);
            chk($sformatf("%s/c%0d", name, i), 32'(obs & m), 32'(f_val(q[i], imm_of(op)) & m));
`ifdef MC_ILLEGAL_TRAP_EN
            chk($sformatf("%s/c%0d/illegal_op", name, i), illegal_op, (q[i].st == 11) ? 1 : 0);
`endif
            if (instr_done === 1'b1 && done_at < 0) done_at = i + 1;
            @(negedge clk);
        end
        chk({name, "/latency"}, done_at, exp_lat);
        q.delete();
    endtask

    initial begin
        int kind, sf, sm, ab;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit z;

        rst = 1'b1; mem_ready = 1'b1; Zero = 1'b0;
        Op = 7'b0000011; funct3 = 3'b010; funct7 = 7'd0;
        @(negedge clk);
        do_reset();

        run_instr("lw",      K_LW,  7'b0000011, 3'b010, 7'd0,        0, 0, 1'b0, -1);
        run_instr("sw",      K_SW,  7'b0100011, 3'b010, 7'd0,        0, 3, 1'b0, -1);
        run_instr("sub",     K_R,   7'b0110011, 3'b000, 7'b0100000,  0, 0, 1'b0, -1);
        run_instr("addi_f7", K_I,   7'b0010011, 3'b000, 7'b0100000,  1, 0, 1'b0, -1);
        run_instr("beq_z1",  K_BEQ, 7'b1100011, 3'b000, 7'd0,        0, 0, 1'b1, -1);
        run_instr("beq_z0",  K_BEQ, 7'b1100011, 3'b000, 7'd0,        0, 0, 1'b0, -1);
        run_instr("jal",     K_JAL, 7'b1101111, 3'b000, 7'd0,        2, 0, 1'b0, -1);
        run_instr("lw_rd_stall", K_LW, 7'b0000011, 3'b010, 7'd0,     0, 2, 1'b0, -1);
        run_instr("lw_abort",    K_LW, 7'b0000011, 3'b010, 7'd0,     0, 0, 1'b0, 4);
        run_instr("sw_abort",    K_SW, 7'b0100011, 3'b010, 7'd0,     0, 2, 1'b0, 4);
        run_instr("illegal", K_NOP, 7'b0000000, 3'b000, 7'd0,        0, 0, 1'b0, -1);
        if (TRAP_EN) do_reset();

        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, TRAP_EN ? 5 : 6);
            case (kind)
                K_LW:    op = 7'b0000011;
                K_SW:    op = 7'b0100011;
                K_R:     op = 7'b0110011;
                K_I:     op = 7'b0010011;
                K_BEQ:   op = 7'b1100011;
                K_JAL:   op = 7'b1101111;
                default: begin
                    op = 7'($urandom_range(0, 127));
                    while (supported(op)) op = 7'($urandom_range(0, 127));
                end
            endcase
            f3 = 3'($urandom_range(0, 7));
            f7 = rb() ? 7'b0100000 : 7'($urandom_range(0, 127));
            sf = $urandom_range(0, 2);
            sm = $urandom_range(0, 3);
            z  = rb();
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
            run_instr($sformatf("rnd%0d_k%0d", n, kind), kind, op, f3, f7, sf, sm, z, ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle sequencing FSM for the RISC-V processing element. It replaces single-cycle decode with a per-instruction state walk that reuses one ALU and one unified instruction/data memory port. It drives datapath mux selects and write enables each cycle, and it stalls on a memory-ready handshake. Supported instructions: lw, sw, R-type, I-type ALU, beq and jal.

Parameters:
STATE_W, 4, width of the state register and the state_o debug port
RESET_STATE, 4'd0, state loaded on reset (FETCH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
Op  input  7  opcode field of the instruction register
funct3  input  3  funct3 field
funct7  input  7  funct7 field
Zero  input  1  ALU zero flag
mem_ready  input  1  memory has completed the current access
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
IRWrite  output  1  instruction register and OldPC enable
MemWrite  output  1  data memory write strobe
RegWrite  output  1  register file write enable
ResultSrc  output  2  result select: 00 = ALUOut, 01 = read data, 10 = ALUResult
ALUSrcA  output  2  A select: 00 = PC, 01 = OldPC, 10 = rs1
ALUSrcB  output  2  B select: 00 = rs2, 01 = imm, 10 = const 4
ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
instr_done  output  1  one-cycle pulse on the last cycle of each instruction
state_o  output  STATE_W  current state (debug)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1, state loads FETCH and PCWrite, IRWrite, MemWrite, RegWrite and instr_done are forced to 0. The first fetch occurs on the first cycle after rst falls.
- Outputs are Moore decodes of the state register. The only Mealy terms are mem_ready gating and Zero on the branch.
- ImmSrc is decoded combinationally from Op in every state: lw/I-ALU = 00, sw = 01, beq = 10, jal = 11, other = 00.
- States and encodings:
  - FETCH (0): AdrSrc=0; ALUSrcA=00; ALUSrcB=10; ALUOp=add; ResultSrc=10. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
  - DECODE (1): ALUSrcA=01; ALUSrcB=01; add (branch target into ALUOut). Next state: lw/sw -> MEMADR, R -> EXECUTER, I-ALU -> EXECUTEI, beq -> BEQ, jal -> JAL, any other opcode -> FETCH with instr_done=1 (treated as NOP).
  - MEMADR (2): ALUSrcA=10; ALUSrcB=01; add. Next state: lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD (3): AdrSrc=1; ResultSrc=00. Holds until mem_ready, then goes to MEMWB.
  - MEMWB (4): ResultSrc=01; RegWrite=1; instr_done=1. Next state: FETCH.
  - MEMWRITE (5): AdrSrc=1; MemWrite=1 for every cycle spent in the state. Holds until mem_ready, then instr_done=1 and next state FETCH.
  - EXECUTER (6): ALUSrcA=10; ALUSrcB=00; ALUOp=funct. Next state: ALUWB.
  - EXECUTEI (7): ALUSrcA=10; ALUSrcB=01; ALUOp=funct. Next state: ALUWB.
  - ALUWB (8): ResultSrc=00; RegWrite=1; instr_done=1. Next state: FETCH.
  - BEQ (9): ALUSrcA=10; ALUSrcB=00; sub; ResultSrc=00. PCWrite=Zero; instr_done=1. Next state: FETCH.
  - JAL (10): ALUSrcA=01; ALUSrcB=10; add; ResultSrc=00. PCWrite=1; RegWrite deferred to ALUWB. Next state: ALUWB.
  - Encodings 11-15 are unreachable and recover to FETCH on the next clock.
- ALUOp to ALUControl mapping:
  - add -> 000; sub -> 001.
  - funct: funct3 000 -> sub if Op[5] & funct7[5], else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
- Latency: lw 5 cycles; sw 4; R/I 4; beq 3; jal 4. Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Boundary conditions:
  - rst asserted mid-instruction aborts it; no write enable fires in that cycle.
  - mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
  - beq with Zero=0 takes no PC update and still returns to FETCH.

Optional Feature:
Macro: MC_ILLEGAL_TRAP_EN
- Defined:
  - An unsupported opcode in DECODE moves to TRAP (encoding 11).
  - TRAP holds all enables at 0 and adds output illegal_op=1, which stays high until rst.
  - instr_done is not pulsed for the illegal instruction.
- Undefined: no illegal_op port; an unsupported opcode is a NOP (DECODE -> FETCH, instr_done=1).

Decomposition:
- Package mc_pkg: state enum and encodings; opcode constants (LW 0000011, SW 0100011, RTYPE 0110011, ITYPE 0010011, BEQ 1100011, JAL 1101111); ALUControl codes; ALUSrcA, ALUSrcB and ResultSrc select codes; ALUOp codes.
- Sub-module mc_alu_op_decoder: combinational mapping from ALUOp, funct3, funct7 and Op to ALUControl. The FSM itself remains in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> state_o=0 and all enables 0 during reset; on the first free cycle IRWrite=1 while mem_ready=1.
- lw, Op=0000011, mem_ready tied to 1 -> states 0,1,2,3,4; RegWrite=1 with ResultSrc=01 only in cycle 5; instr_done pulses once.
- sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles; ImmSrc=01; returns to FETCH.
- R-type sub (funct3=000, funct7=0100000) -> ALUControl=001 in EXECUTER; ALUWB asserts RegWrite; total 4 cycles.
- beq with Zero=1, then with Zero=0 -> PCWrite=1 in BEQ in the first case, 0 in the second; both take 3 cycles.
- Opcode 0000000 -> NOP returns to FETCH without the macro; with MC_ILLEGAL_TRAP_EN, state_o=11, illegal_op=1, and both clear only on rst.
